// File: rtl/uart_debug_responder_if.sv
// Debug responder bus bundle: rx fifo head/pop, tx fifo push, pipeline step/run and register-read hooks.
// master = responder side, slave = UART fifos plus datapath debug hooks.
interface uart_debug_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              data_available;
    logic [7:0]        rx_data;
    logic              read_flag;
    logic              tx_full;
    logic              write_flag;
    logic [7:0]        tx_data;
    logic              step_pulse;
    logic              run_mode;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [DATA_W-1:0] pc_value;
    logic              busy;

    modport master (
        input  data_available, rx_data, tx_full, dbg_data, pc_value,
        output read_flag, write_flag, tx_data, step_pulse, run_mode, dbg_addr, busy
    );

    modport slave (
        output data_available, rx_data, tx_full, dbg_data, pc_value,
        input  read_flag, write_flag, tx_data, step_pulse, run_mode, dbg_addr, busy
    );
endinterface

// File: rtl/uart_debug_responder.sv
// UART debug command responder: pops opcode/argument bytes, drives step/run/reg-read, pushes replies MSB first.
// Latency: reply starts 2 cycles after opcode pop (READ_REG: 3 cycles after argument pop); one idle cycle between tx writes.
// Backpressure: tx_full holds SEND with byte unchanged; rx bytes left in fifo while busy. UART_DBG_CHECKSUM_EN appends XOR byte.
module uart_debug_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int ARG_TIMEOUT = 1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_debug_responder_if.master bus
);

    localparam logic [7:0] OP_STEP     = 8'h01;
    localparam logic [7:0] OP_READ_REG = 8'h02;
    localparam logic [7:0] OP_TOGGLE   = 8'h03;
    localparam logic [7:0] OP_READ_PC  = 8'h04;
    localparam logic [7:0] ACK         = 8'h06;
    localparam logic [7:0] NAK         = 8'h15;

    localparam int NBYTES = DATA_W / 8;
`ifdef UART_DBG_CHECKSUM_EN
    localparam int NREPLY = NBYTES + 1;
`else
    localparam int NREPLY = NBYTES;
`endif
    localparam int CNT_W = $clog2(NREPLY + 1);
    localparam int TO_W  = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT_ARG,
        FETCH,
        CAPTURE,
        SEND
    } state_t;

    state_t            state;
    logic [7:0]        opcode;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  byte_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              gap;
    logic              run_q;
    logic [7:0]        tx_q;
    logic [ADDR_W-1:0] addr_q;
`ifdef UART_DBG_CHECKSUM_EN
    logic [7:0]        csum;
    logic              csum_en;
`endif

    logic pop;
    logic wr;

    // Pop and push are same-cycle strobes; the state sequence guarantees a gap between pops.
    assign pop = reset && bus.data_available && ((state == IDLE) || (state == WAIT_ARG));
    assign wr  = reset && (state == SEND) && !gap && !bus.tx_full;

    assign bus.read_flag  = pop;
    assign bus.write_flag = wr;
    assign bus.tx_data    = tx_q;
    assign bus.step_pulse = (state == DECODE) && (opcode == OP_STEP);
    assign bus.run_mode   = run_q;
    assign bus.dbg_addr   = addr_q;
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            opcode   <= 8'h00;
            shreg    <= '0;
            byte_cnt <= '0;
            to_cnt   <= '0;
            gap      <= 1'b0;
            run_q    <= 1'b0;
            tx_q     <= 8'h00;
            addr_q   <= '0;
`ifdef UART_DBG_CHECKSUM_EN
            csum     <= 8'h00;
            csum_en  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        opcode <= bus.rx_data;
                        state  <= DECODE;
                    end
                end
                DECODE: begin
                    // Default is a single NAK; known opcodes override below.
                    byte_cnt <= CNT_W'(1);
                    gap      <= 1'b0;
                    tx_q     <= NAK;
                    state    <= SEND;
`ifdef UART_DBG_CHECKSUM_EN
                    csum     <= 8'h00;
                    csum_en  <= 1'b0;
`endif
                    case (opcode)
                        OP_STEP:   tx_q <= ACK;
                        OP_TOGGLE: begin
                            run_q <= ~run_q;
                            tx_q  <= ACK;
                        end
                        OP_READ_PC: begin
                            tx_q     <= bus.pc_value[DATA_W-1 -: 8];
                            shreg    <= bus.pc_value << 8;
                            byte_cnt <= CNT_W'(NREPLY);
`ifdef UART_DBG_CHECKSUM_EN
                            csum_en  <= 1'b1;
`endif
                        end
                        OP_READ_REG: begin
                            to_cnt <= '0;
                            state  <= WAIT_ARG;
                        end
                        default: ;
                    endcase
                end
                WAIT_ARG: begin
                    if (pop) begin
                        addr_q <= bus.rx_data[ADDR_W-1:0];
                        state  <= FETCH;
                    end else if (to_cnt == TO_W'(ARG_TIMEOUT - 1)) begin
                        tx_q     <= NAK;
                        byte_cnt <= CNT_W'(1);
                        gap      <= 1'b0;
`ifdef UART_DBG_CHECKSUM_EN
                        csum_en  <= 1'b0;
`endif
                        state    <= SEND;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                FETCH: state <= CAPTURE;
                CAPTURE: begin
                    tx_q     <= bus.dbg_data[DATA_W-1 -: 8];
                    shreg    <= bus.dbg_data << 8;
                    byte_cnt <= CNT_W'(NREPLY);
                    gap      <= 1'b0;
`ifdef UART_DBG_CHECKSUM_EN
                    csum     <= 8'h00;
                    csum_en  <= 1'b1;
`endif
                    state    <= SEND;
                end
                SEND: begin
                    if (gap) begin
                        gap <= 1'b0;
                    end else if (!bus.tx_full) begin
`ifdef UART_DBG_CHECKSUM_EN
                        csum <= csum ^ tx_q;
`endif
                        if (byte_cnt == CNT_W'(1)) begin
                            state <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt - CNT_W'(1);
                            gap      <= 1'b1;
`ifdef UART_DBG_CHECKSUM_EN
                            // Last slot carries the running XOR including the byte going out now.
                            if (csum_en && (byte_cnt == CNT_W'(2))) begin
                                tx_q <= csum ^ tx_q;
                            end else begin
                                tx_q  <= shreg[DATA_W-1 -: 8];
                                shreg <= shreg << 8;
                            end
`else
                            tx_q  <= shreg[DATA_W-1 -: 8];
                            shreg <= shreg << 8;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_debug_responder.sv
// Self-checking bench for uart_debug_responder: vector table plus timeout, tx backpressure and mid-reply reset sequences.
module tb_uart_debug_responder;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 5;
    localparam int ARG_TIMEOUT = 16;
`ifdef UART_DBG_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_debug_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    uart_debug_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ARG_TIMEOUT(ARG_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // rx fifo model: main writes rx_arr/rx_wr, driver owns pops_done
    logic [7:0] rx_arr [0:511];
    int rx_wr = 0;
    int pops_done = 0;

    // monitor-owned state
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, step_cnt = 0;
    int last_pop_cyc = 0, last_wr_cyc = 0;
    int gap_viol = 0, full_viol = 0, pop_viol = 0;
    bit prev_wr = 1'b0, prev_rd = 1'b0;
    logic [7:0] wr_log [0:1023];

    logic [7:0] exp_q [$];
    int cmp_idx = 0;

    always @(posedge clock) begin
        bus.dbg_data <= (bus.dbg_addr == 5'd7) ? 32'hDEADBEEF : (32'h12345600 | 32'(bus.dbg_addr));
    end

    always @(posedge clock) begin
        #1;
        if (pops_done < rd_cnt) pops_done = pops_done + 1;
        bus.data_available = (pops_done < rx_wr);
        bus.rx_data        = (pops_done < rx_wr) ? rx_arr[pops_done] : 8'h00;
    end

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            if (bus.read_flag) begin
                if (prev_rd) pop_viol = pop_viol + 1;
                rd_cnt       = rd_cnt + 1;
                last_pop_cyc = cyc;
            end
            if (bus.step_pulse) step_cnt = step_cnt + 1;
            if (bus.write_flag) begin
                if (prev_wr) gap_viol = gap_viol + 1;
                if (bus.tx_full) full_viol = full_viol + 1;
                wr_log[wr_cnt] = bus.tx_data;
                wr_cnt         = wr_cnt + 1;
                last_wr_cyc    = cyc;
            end
        end
        prev_rd = reset && bus.read_flag;
        prev_wr = reset && bus.write_flag;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drain();
        while (cmp_idx < wr_cnt) begin
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_write actual=%0h required=none", wr_log[cmp_idx]);
            end else begin
                chk("reply_byte", 32'(wr_log[cmp_idx]), 32'(exp_q.pop_front()));
            end
            cmp_idx = cmp_idx + 1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
        drain();
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_arr[rx_wr] = b;
        rx_wr = rx_wr + 1;
    endtask

    function automatic bit is_idle();
        return (pops_done == rx_wr) && (exp_q.size() == 0) && (bus.busy == 1'b0) && (cmp_idx == wr_cnt);
    endfunction

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (!is_idle() && n < budget) begin
            tick();
            n = n + 1;
        end
        chk({nm, "_completed"}, 32'(is_idle()), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic        has_arg;
        logic [7:0]  arg;
        logic [31:0] pc;
        logic [39:0] rep;
        int          n;
        int          steps;
        logic        run;
        logic [4:0]  addr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int step_base, rd_base, wr_base, n;

        bus.tx_full  = 1'b0;
        bus.pc_value = '0;

        // Data replies carry the XOR byte in rep[7:0]; n selects whether it is sent.
        tbl[0]  = '{8'h01, 1'b0, 8'h00, 32'h0,        {8'h06, 32'h0},         1,      1, 1'b0, 5'd0};
        tbl[1]  = '{8'h04, 1'b0, 8'h00, 32'h00400010, {32'h00400010, 8'h50},  4 + CS, 0, 1'b0, 5'd0};
        tbl[2]  = '{8'h02, 1'b1, 8'h07, 32'h0,        {32'hDEADBEEF, 8'h22},  4 + CS, 0, 1'b0, 5'd7};
        tbl[3]  = '{8'h03, 1'b0, 8'h00, 32'h0,        {8'h06, 32'h0},         1,      0, 1'b1, 5'd0};
        tbl[4]  = '{8'h01, 1'b0, 8'h00, 32'h0,        {8'h06, 32'h0},         1,      1, 1'b1, 5'd0};
        tbl[5]  = '{8'h02, 1'b1, 8'hE3, 32'h0,        {32'h12345603, 8'h73},  4 + CS, 0, 1'b1, 5'd3};
        tbl[6]  = '{8'h03, 1'b0, 8'h00, 32'h0,        {8'h06, 32'h0},         1,      0, 1'b0, 5'd0};
        tbl[7]  = '{8'h7F, 1'b0, 8'h00, 32'h0,        {8'h15, 32'h0},         1,      0, 1'b0, 5'd0};
        tbl[8]  = '{8'h00, 1'b0, 8'h00, 32'h0,        {8'h15, 32'h0},         1,      0, 1'b0, 5'd0};
        tbl[9]  = '{8'h04, 1'b0, 8'h00, 32'hFFFFFFFF, {32'hFFFFFFFF, 8'h00},  4 + CS, 0, 1'b0, 5'd0};
        tbl[10] = '{8'h02, 1'b1, 8'h1F, 32'h0,        {32'h1234561F, 8'h6F},  4 + CS, 0, 1'b0, 5'd31};
        tbl[11] = '{8'hFF, 1'b0, 8'h00, 32'h0,        {8'h15, 32'h0},         1,      0, 1'b0, 5'd0};

        repeat (3) @(posedge clock);
        #2;
        chk("rst_read_flag",  32'(bus.read_flag),  32'd0);
        chk("rst_write_flag", 32'(bus.write_flag), 32'd0);
        chk("rst_step_pulse", 32'(bus.step_pulse), 32'd0);
        chk("rst_run_mode",   32'(bus.run_mode),   32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_tx_data",    32'(bus.tx_data),    32'd0);
        chk("rst_dbg_addr",   32'(bus.dbg_addr),   32'd0);
        reset = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 12; i++) begin
            bus.pc_value = tbl[i].pc;
            step_base = step_cnt;
            rd_base   = rd_cnt;
            for (int j = 0; j < tbl[i].n; j++) begin
                logic [39:0] r;
                r = tbl[i].rep;
                exp_q.push_back(r[39 - 8*j -: 8]);
            end
            push_rx(tbl[i].op);
            if (tbl[i].has_arg) push_rx(tbl[i].arg);
            wait_idle(300, "vec");
            chk("vec_step_count", 32'(step_cnt - step_base), 32'(tbl[i].steps));
            chk("vec_pop_count",  32'(rd_cnt - rd_base),     32'(1 + int'(tbl[i].has_arg)));
            chk("vec_run_mode",   32'(bus.run_mode),         32'(tbl[i].run));
            if (tbl[i].has_arg) chk("vec_dbg_addr", 32'(bus.dbg_addr), 32'(tbl[i].addr));
        end

        // Argument timeout: pop P, DECODE P+1, WAIT_ARG P+2..P+17 (count 0..15), NAK written at P+18.
        rd_base = rd_cnt;
        exp_q.push_back(8'h15);
        push_rx(8'h02);
        wait_idle(100, "timeout");
        chk("timeout_latency", 32'(last_wr_cyc - last_pop_cyc), 32'd18);
        chk("timeout_pops",    32'(rd_cnt - rd_base),           32'd1);
        exp_q.push_back(8'h06);
        push_rx(8'h03);
        wait_idle(100, "toggle_after_timeout");
        chk("toggle_run_on", 32'(bus.run_mode), 32'd1);

        // tx fifo full for 50 cycles during a READ_PC reply
        bus.tx_full  = 1'b1;
        bus.pc_value = 32'h00400010;
        for (int j = 0; j < 4 + CS; j++) begin
            logic [39:0] r;
            r = {32'h00400010, 8'h50};
            exp_q.push_back(r[39 - 8*j -: 8]);
        end
        wr_base = wr_cnt;
        push_rx(8'h04);
        repeat (50) tick();
        chk("full_no_writes",  32'(wr_cnt - wr_base), 32'd0);
        chk("full_busy_held",  32'(bus.busy),         32'd1);
        chk("full_byte_held",  32'(bus.tx_data),      32'h00);
        bus.tx_full = 1'b0;
        wait_idle(100, "full_release");
        chk("full_total_writes", 32'(wr_cnt - wr_base), 32'(4 + CS));

        // reset asserted in the gap after the first reply byte
        for (int j = 0; j < 4 + CS; j++) begin
            logic [39:0] r;
            r = {32'h00400010, 8'h50};
            exp_q.push_back(r[39 - 8*j -: 8]);
        end
        wr_base = wr_cnt;
        push_rx(8'h04);
        n = 0;
        while (wr_cnt == wr_base && n < 100) begin
            tick();
            n = n + 1;
        end
        chk("midrst_first_write", 32'(wr_cnt - wr_base), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        tick();
        chk("midrst_write_flag", 32'(bus.write_flag), 32'd0);
        chk("midrst_run_mode",   32'(bus.run_mode),   32'd0);
        chk("midrst_busy",       32'(bus.busy),       32'd0);
        chk("midrst_tx_data",    32'(bus.tx_data),    32'd0);
        tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("midrst_no_more_writes", 32'(wr_cnt - wr_base), 32'd1);
        chk("midrst_idle",           32'(bus.busy),         32'd0);

        chk("write_gap_violations", 32'(gap_viol),  32'd0);
        chk("write_while_full",     32'(full_viol), 32'd0);
        chk("back_to_back_pops",    32'(pop_viol),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
